// File: rtl/pmod_meter_pkg.sv
// pmod_meter_pkg: shared state encoding and default widths for the PMOD period meter
package pmod_meter_pkg;
  typedef enum logic {IDLE, MEASURE} meter_state_t;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int EDGE_CNT_WIDTH_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2 ** 24;
  localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: synchronise async din through STAGES flops (clk, rst, din in; level, rise out)
module sync_rise_detect
  import pmod_meter_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int N = STAGES < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : STAGES;
  logic [N-1:0] sr;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[N-2:0], din};
      prev <= sr[N-1];
    end
  end
  assign level = sr[N-1];
  assign rise = sr[N-1] & ~prev;
endmodule

// File: rtl/pmod_period_meter.sv
// pmod_period_meter: measure period/high time of async pmod_in (clk200, rst, pmod_in, clear in; period, high_time, period_valid, locked, timeout, edge_cnt out)
module pmod_period_meter
  import pmod_meter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int EDGE_CNT_WIDTH = EDGE_CNT_WIDTH_DEF
) (
  input  logic                      clk200,
  input  logic                      rst,
  input  logic                      pmod_in,
  input  logic                      clear,
  output logic [CNT_WIDTH-1:0]      period,
  output logic [CNT_WIDTH-1:0]      high_time,
  output logic                      period_valid,
  output logic                      locked,
  output logic                      timeout,
  output logic [EDGE_CNT_WIDTH-1:0] edge_cnt
);
  localparam logic [CNT_WIDTH-1:0] TO = CNT_WIDTH'(TIMEOUT_CYCLES);
  meter_state_t state, state_next;
  logic level, rise, timed_out;
  logic [CNT_WIDTH-1:0] cnt, high_cnt, cnt_inc, high_inc;
  sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk200),
    .rst(rst),
    .din(pmod_in),
    .level(level),
    .rise(rise)
  );
  always_comb begin
    cnt_inc = &cnt ? cnt : cnt + CNT_WIDTH'(1);
    high_inc = &high_cnt ? high_cnt : high_cnt + CNT_WIDTH'(1);
    timed_out = state == MEASURE && !rise && cnt_inc == TO;
    state_next = clear ? IDLE : rise ? MEASURE : timed_out ? IDLE : state;
  end
  always_ff @(posedge clk200) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk200) begin
    if (rst || clear) begin
      cnt <= '0;
      high_cnt <= '0;
      period <= '0;
      high_time <= '0;
      period_valid <= 1'b0;
      locked <= 1'b0;
      timeout <= 1'b0;
      edge_cnt <= '0;
    end else begin
      period_valid <= state == MEASURE && rise;
      if (rise) begin
        edge_cnt <= edge_cnt + EDGE_CNT_WIDTH'(1);
        cnt <= '0;
        high_cnt <= CNT_WIDTH'(1);
        if (state == MEASURE) begin
          period <= cnt_inc;
          high_time <= high_cnt;
          locked <= 1'b1;
        end
      end else if (state == MEASURE) begin
        cnt <= cnt_inc;
        high_cnt <= level ? high_inc : high_cnt;
        if (timed_out) begin
          locked <= 1'b0;
          timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pmod_period_meter.sv
// tb_pmod_period_meter: randomized self-checking bench against an edge-index arithmetic model
module tb_pmod_period_meter;
  localparam int TO = 64;
  logic clk200 = 1'b0;
  logic rst = 1'b1;
  logic pmod_in = 1'b0;
  logic clear = 1'b0;
  logic [31:0] period, high_time;
  logic period_valid, locked, timeout;
  logic [3:0] edge_cnt;
  int checks = 0;
  int errors = 0;
  pmod_period_meter #(
    .CNT_WIDTH(32),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TO),
    .EDGE_CNT_WIDTH(4)
  ) dut (
    .clk200(clk200),
    .rst(rst),
    .pmod_in(pmod_in),
    .clear(clear),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout),
    .edge_cnt(edge_cnt)
  );
  always #5 clk200 = ~clk200;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
  task automatic do_clear();
    @(negedge clk200);
    clear = 1'b1;
    @(negedge clk200);
    clear = 1'b0;
  endtask
  task automatic check_zero(input string name);
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL %s period_valid got %0b exp 0", name, period_valid); end
    checks++; if (period !== 32'd0) begin errors++; $display("FAIL %s period got %0d exp 0", name, period); end
    checks++; if (high_time !== 32'd0) begin errors++; $display("FAIL %s high_time got %0d exp 0", name, high_time); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL %s locked got %0b exp 0", name, locked); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s timeout got %0b exp 0", name, timeout); end
    checks++; if (edge_cnt !== 4'd0) begin errors++; $display("FAIL %s edge_cnt got %0d exp 0", name, edge_cnt); end
  endtask
  // Square wave of n periods (p cycles, h high) starting low; the model predicts every
  // output from the sample-edge index e at which each rise is seen (registered 2 edges later).
  task automatic run_wave(input string name, input int p, input int h, input int n,
                          input int tail, input int ec0, input bit to0);
    int total, last_reg, e, nr;
    bit x_pv, x_lock, x_to;
    logic [3:0] x_ec;
    total = n * p + tail;
    last_reg = (n - 1) * p + 2;
    for (int t = 0; t <= total; t++) begin
      @(negedge clk200);
      if (t > 0) begin
        e = t - 1;
        x_pv = (e >= p + 2) && (e <= last_reg) && ((e - 2) % p == 0);
        nr = (e < 2) ? 0 : (((e - 2) / p + 1) > n ? n : (e - 2) / p + 1);
        x_lock = (n >= 2) && (e >= p + 2) && (e < last_reg + TO);
        x_to = to0 || (e >= last_reg + TO);
        x_ec = 4'(ec0 + nr);
        checks++; if (period_valid !== x_pv) begin errors++; $display("FAIL %s period_valid e=%0d got %0b exp %0b", name, e, period_valid, x_pv); end
        checks++; if (locked !== x_lock) begin errors++; $display("FAIL %s locked e=%0d got %0b exp %0b", name, e, locked, x_lock); end
        checks++; if (timeout !== x_to) begin errors++; $display("FAIL %s timeout e=%0d got %0b exp %0b", name, e, timeout, x_to); end
        checks++; if (edge_cnt !== x_ec) begin errors++; $display("FAIL %s edge_cnt e=%0d got %0d exp %0d", name, e, edge_cnt, x_ec); end
        if (x_pv) begin
          checks++; if (period !== 32'(p)) begin errors++; $display("FAIL %s period e=%0d got %0d exp %0d", name, e, period, p); end
          checks++; if (high_time !== 32'(h)) begin errors++; $display("FAIL %s high_time e=%0d got %0d exp %0d", name, e, high_time, h); end
        end
      end
      #($urandom_range(0, 4));
      pmod_in = (t < n * p) && (t % p < h);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    pmod_in = 1'b0;
    repeat (5) @(posedge clk200);
    @(negedge clk200);
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk200);
      checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_idle period_valid cyc=%0d got %0b exp 0", i, period_valid); end
    end
  endtask
  task automatic test_duty50();
    do_clear();
    run_wave("duty50", 16, 8, 6, 4, 0, 1'b0);
  endtask
  task automatic test_duty25();
    do_clear();
    run_wave("duty25", 20, 5, 5, 4, 0, 1'b0);
  endtask
  task automatic test_timeout();
    do_clear();
    run_wave("timeout", 16, 8, 3, 80, 0, 1'b0);
    run_wave("restart", 16, 8, 3, 6, 3, 1'b1);
    do_clear();
    @(negedge clk200);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear timeout got %0b exp 0", timeout); end
  endtask
  task automatic test_clear_collision();
    do_clear();
    run_wave("pre_collision", 10, 5, 3, 5, 0, 1'b0);
    @(negedge clk200);
    #1 pmod_in = 1'b1;
    @(negedge clk200);
    @(negedge clk200);
    clear = 1'b1;
    @(negedge clk200);
    clear = 1'b0;
    check_zero("collision");
    for (int i = 0; i < 24; i++) begin
      @(negedge clk200);
      if (i == 10) pmod_in = 1'b0;
      if (i == 16) pmod_in = 1'b1;
      checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL collision_idle period_valid cyc=%0d got %0b exp 0", i, period_valid); end
    end
    checks++; if (edge_cnt !== 4'd1) begin errors++; $display("FAIL collision_idle edge_cnt got %0d exp 1", edge_cnt); end
    pmod_in = 1'b0;
    repeat (4) @(negedge clk200);
  endtask
  task automatic test_reset_mid();
    do_clear();
    run_wave("pre_reset", 10, 5, 3, 0, 0, 1'b0);
    pmod_in = 1'b1;
    repeat (4) @(negedge clk200);
    rst = 1'b1;
    repeat (2) @(negedge clk200);
    check_zero("reset_mid");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk200);
      checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_mid period_valid cyc=%0d got %0b exp 0", i, period_valid); end
    end
    checks++; if (edge_cnt !== 4'd1) begin errors++; $display("FAIL reset_mid edge_cnt got %0d exp 1", edge_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_mid locked got %0b exp 0", locked); end
    pmod_in = 1'b0;
    repeat (4) @(negedge clk200);
  endtask
  task automatic test_wrap();
    do_clear();
    run_wave("wrap", 6, 3, 17, 4, 0, 1'b0);
    checks++; if (edge_cnt !== 4'd1) begin errors++; $display("FAIL wrap_final edge_cnt got %0d exp 1", edge_cnt); end
  endtask
  task automatic test_random();
    int p, h, n;
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(2, 40);
      h = $urandom_range(1, p - 1);
      n = $urandom_range(2, 6);
      do_clear();
      run_wave($sformatf("random%0d_p%0d_h%0d", r, p, h), p, h, n, 4, 0, 1'b0);
    end
  endtask
  initial begin
    test_reset();
    test_duty50();
    test_duty25();
    test_timeout();
    test_clear_collision();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmod_period_meter.md
# pmod_period_meter

Input-side measurement block for the ZC702 PL designs, running on `clk200`. It takes an asynchronous square wave on a PMOD pin, for example the free-running counter MSB driven by another board or looped back from PMOD1[0]. It synchronises the wave, detects rising edges, and reports period, high time, edge count, lock and timeout status. Its outputs feed ILA and debug logic in the shell.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of the period and high-time counters.
- `SYNC_STAGES`, 2, number of synchroniser flops; minimum 2.
- `TIMEOUT_CYCLES`, 2**24, count of `clk200` cycles with no rising edge that drops lock; must be ≤ 2**CNT_WIDTH−1.
- `EDGE_CNT_WIDTH`, 16, width of the rising-edge counter.

Ports:
- `clk200`  in  1  200 MHz fabric clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `pmod_in`  in  1  asynchronous square-wave input.
- `clear`  in  1  synchronous one-cycle pulse; restarts measurement and clears the sticky flags.
- `period`  out  CNT_WIDTH  last measured rise-to-rise interval, in cycles.
- `high_time`  out  CNT_WIDTH  high cycles within that interval.
- `period_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  at least one valid period captured since the last restart, with no timeout since.
- `timeout`  out  1  sticky; set on timeout, cleared by `clear` or `rst`.
- `edge_cnt`  out  EDGE_CNT_WIDTH  rising edges detected; wraps.

## Operation
Input path:
- `pmod_in` passes through `SYNC_STAGES` flops.
- A `prev` register holds the last synchronised level.
- `rise` = sync & ~prev.

State machine:
- **IDLE**: waits for `rise`. On `rise`: set `cnt`=0 and `high_cnt`=1, go to MEASURE. No timeout applies in IDLE.
- **MEASURE**: every cycle `cnt`+=1, and `high_cnt`+=1 when the synchronised level is high.
  - On `rise`: `period`←`cnt`+1, `high_time`←`high_cnt`, pulse `period_valid`, set `locked`, then reset `cnt`=0 and `high_cnt`=1.
  - Resulting values: rises N cycles apart give `period`=N. A 50 % duty wave gives `high_time`=N/2.
  - When `cnt`+1 == `TIMEOUT_CYCLES` with no `rise`: go to IDLE, `locked`←0, `timeout`←1.

`edge_cnt` increments on every `rise` in any state, including the first edge in IDLE. It wraps from all-ones to 0.

Counters saturate at all-ones. This is unreachable given the `TIMEOUT_CYCLES` bound but is still required.

Boundary rules:
- `rise` and timeout in the same cycle: `rise` wins. The period is captured and `timeout` is unchanged.
- `clear` and `rise` in the same cycle: `clear` wins. State→IDLE, no `period_valid`, and that edge is not counted in `edge_cnt`.
- `clear` in any state: state→IDLE; `period`, `high_time`, `edge_cnt`, `locked` and `timeout` all →0.
- `rst` mid-measurement: identical to `clear`. The synchroniser and `prev` also reset to 0, so a high input at reset release produces one `rise`.

Reset values: state IDLE, all outputs 0, synchroniser 0, `prev` 0.

## Timing
- Define edge k as the first `clk200` edge at which the high level of `pmod_in` is sampled.
- `period`, `high_time`, `period_valid`, `edge_cnt` and `locked` update at edge k+SYNC_STAGES. With the default, that is edge k+2.
- `period_valid` is high for exactly one cycle per captured period.
- `timeout` and the `locked` fall update on the edge where `cnt`+1 reaches `TIMEOUT_CYCLES`. That is `TIMEOUT_CYCLES` cycles after the edge that registered the last `rise`.
- `clear` takes effect on the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum measurable period is 2 cycles. Input pulses shorter than 1 cycle may be missed; this is accepted behaviour.

## Structure
- Package `pmod_meter_pkg` holds:
  - the `meter_state_t` enum {IDLE, MEASURE};
  - default width constants;
  - `SYNC_STAGES_MIN`=2.
- Sub-module `sync_rise_detect` holds the synchroniser chain, the `prev` register and the `rise` output. It is parameterised by `SYNC_STAGES`, is reset by `rst`, and is reusable for `GPIO_SW_N` handling.
- The top level holds the FSM, counters and output registers.

## Test plan
- **Reset**: hold `rst` for 5 cycles with `pmod_in`=0. Required: all outputs 0, and no `period_valid` for 100 cycles.
- **50 % duty**: square wave of period 16 (8 high / 8 low), phase-jittered against `clk200`. Required: first `period_valid` on the second rise with `period`=16 and `high_time`=8; `locked`=1; `edge_cnt`=2.
- **25 % duty**: period 20 (5 high / 15 low). Required: every `period_valid` reports `period`=20 and `high_time`=5, one pulse per 20 cycles.
- **Timeout** (`TIMEOUT_CYCLES`=64): stop toggling after lock. Required: `locked`→0 and `timeout`→1 exactly 64 cycles after the last `rise` registration. Restarting the wave needs two rises for a new `period_valid`, and `timeout` stays 1 until `clear`.
- **Clear collision**: `clear` asserted in the same cycle as `rise`. Required: no `period_valid`, all outputs 0, `edge_cnt`=0, state IDLE.
- **Wrap** (`EDGE_CNT_WIDTH`=4): 17 rises. Required: `edge_cnt` reads 15 after the 15th rise and 1 after the 17th.
